sys_skew_feeder: RTL and testbench

Upstream operand feeder for the systolic MAC array. It accepts one N-lane operand vector per beat from the tile buffer and presents the lanes to the array edge with a diagonal skew: lane i is delayed i cycles relative to lane 0. The skew makes row/column elements meet at the correct MAC cell. After the last vector it flushes the skew pipeline with zeros and pulses `done`. Two instances are used, one for the left edge and one for the top edge. Both instances share `stall` and receive identical `start`/`len`/`in_valid` timing.

---
 rtl/sys_skew_feeder.sv | 123 ++++++++++++
 tb/tb_sys_skew_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_skew_feeder.sv
// Operand feeder for the systolic MAC array edge: lane i of each accepted vector is
// presented i cycles after lane 0, and the skew pipeline is flushed with zeros before done.
module sys_skew_feeder #(
    parameter int Data_Width = 8,
    parameter int N          = 4,
    parameter int K_Width    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_Width-1:0]      len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*Data_Width-1:0] in_data,
    input  logic                    stall,
    output logic [N*Data_Width-1:0] out_data,
    output logic [N-1:0]            out_lane_valid,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    localparam int DCW = $clog2(N);
    localparam logic [K_Width-1:0] K_ONE      = K_Width'(1);
    localparam logic [DCW-1:0]     D_ONE      = DCW'(1);
    localparam logic [DCW-1:0]     DRAIN_LAST = DCW'(N - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [K_Width-1:0]      beat_cnt;
    logic [K_Width-1:0]      len_q;
    logic [DCW-1:0]          drain_cnt;
    logic                    advance;
    logic                    accept;
    logic [N*Data_Width-1:0] head_data;

    // Handshake: a beat transfers on a cycle where in_valid and in_ready are both high;
    // in_ready depends only on state and stall, never on in_valid.
    assign advance   = !stall;
    assign in_ready  = (state == FEED) && !stall;
    assign accept    = in_valid && in_ready;
    assign head_data = accept ? in_data : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            len_q     <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else if (advance) begin
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        state    <= FEED;
                        len_q    <= len;
                        beat_cnt <= '0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + K_ONE;
                        if (beat_cnt == len_q - K_ONE) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // N-1 flush cycles push the last element out of the longest lane
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + D_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        // dline[0] is loaded from the head; dline[i] drives the array edge
        logic [Data_Width-1:0] dline [0:i];
        logic [i:0]            vline;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    dline[j] <= '0;
                end
                vline <= '0;
            end else if (advance) begin
                dline[0] <= head_data[i*Data_Width +: Data_Width];
                vline[0] <= accept;
                for (int j = 1; j <= i; j++) begin
                    dline[j] <= dline[j-1];
                    vline[j] <= vline[j-1];
                end
            end
        end

        assign out_data[i*Data_Width +: Data_Width] = dline[i];
        assign out_lane_valid[i]                    = vline[i];
    end

endmodule

// File: tb/tb_sys_skew_feeder.sv
// Bench for sys_skew_feeder: a directed table, corner-case tiles and random traffic,
// all checked against a history-based model of the skew rule.
module tb_sys_skew_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          stall = 1'b0;
  logic [W-1:0]  out_data;
  logic [N-1:0]  out_lane_valid;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  sys_skew_feeder #(.Data_Width(DW), .N(N), .K_Width(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .stall(stall),
    .out_data(out_data), .out_lane_valid(out_lane_valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tile phase plus the head value of each of the last N advance cycles.
  // exp_q[k] is the head from k+1 advance cycles ago, which lane k presents now.
  localparam int M_IDLE = 0, M_FEED = 1, M_DRAIN = 2, M_DONE = 3;
  int           m_state = M_IDLE;
  int           m_len, m_cnt, m_drain;
  logic [W-1:0] exp_q[$];
  logic         vld_q[$];

  logic [W-1:0] o_data;
  logic [N-1:0] o_lv;
  logic         o_busy, o_done, o_ready;

  logic [W-1:0] obs_data [0:31];
  logic [N-1:0] obs_lv   [0:31];
  logic         obs_busy [0:31];
  int           done_cyc;
  logic [W-1:0] tile_v   [0:7];

  typedef struct {
    logic         s;
    logic [KW-1:0] l;
    logic         v;
    logic [W-1:0] d;
    logic [W-1:0] e_data;
    logic [N-1:0] e_lv;
    logic         e_busy;
    logic         e_done;
  } vec_t;
  vec_t tbl [0:8];

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, got, exp);
    end
  endtask

  function automatic int lane_s(input logic [W-1:0] v, input int i);
    logic signed [DW-1:0] b;
    b = v[i*DW +: DW];
    return int'(b);
  endfunction

  function automatic void model_step(input logic r, s, input logic [KW-1:0] l,
                                     input logic v, input logic [W-1:0] d, input logic st);
    logic acc;
    if (r) begin
      m_state = M_IDLE; m_cnt = 0; m_drain = 0;
      exp_q.delete(); vld_q.delete();
      return;
    end
    if (st) return;
    acc = (m_state == M_FEED) && v;
    exp_q.push_front(acc ? d : '0);
    vld_q.push_front(acc);
    if (exp_q.size() > N) begin
      void'(exp_q.pop_back());
      void'(vld_q.pop_back());
    end
    case (m_state)
      M_IDLE:  if (s && l != 0) begin m_state = M_FEED; m_len = int'(l); m_cnt = 0; end
      M_FEED:  if (acc) begin
                 m_cnt++;
                 if (m_cnt == m_len) begin m_state = M_DRAIN; m_drain = 0; end
               end
      M_DRAIN: begin m_drain++; if (m_drain == N - 1) m_state = M_DONE; end
      default: m_state = M_IDLE;
    endcase
  endfunction

  // Drive one cycle, check mid-cycle outputs against the model, then step the model.
  task automatic cycle(input logic r, s, input logic [KW-1:0] l,
                       input logic v, input logic [W-1:0] d, input logic st);
    logic [W-1:0] e_data, qv;
    logic [N-1:0] e_lv;
    rst = r; start = s; len = l; in_valid = v; in_data = d; stall = st;
    #4;
    e_data = '0;
    e_lv   = '0;
    for (int i = 0; i < N; i++) begin
      if (i < exp_q.size()) begin
        qv = exp_q[i];
        e_data[i*DW +: DW] = qv[i*DW +: DW];
        e_lv[i] = vld_q[i];
      end
    end
    o_data = out_data; o_lv = out_lane_valid;
    o_busy = busy; o_done = done; o_ready = in_ready;
    chk("mdl_out_data", o_data, e_data);
    chk("mdl_lane_valid", W'(o_lv), W'(e_lv));
    chk("mdl_in_ready", W'(o_ready), W'((m_state == M_FEED) && !st));
    chk("mdl_busy", W'(o_busy), W'(m_state != M_IDLE));
    chk("mdl_done", W'(o_done), W'(m_state == M_DONE));
    @(posedge clk);
    model_step(r, s, l, v, d, st);
    #1;
  endtask

  task automatic run_tile(input int L, input int st_lo, input int st_hi, input int bub,
                          input int xs, input int rs, input int nc);
    int bi;
    bi = 0;
    done_cyc = -1;
    for (int c = 0; c < nc; c++) begin
      logic s_i, v_i, st_i, r_i;
      logic [KW-1:0] l_i;
      logic [W-1:0] d_i;
      s_i  = (c == 0) || (c == xs);
      l_i  = (c == xs) ? KW'(5) : KW'(L);
      st_i = (c >= st_lo) && (c <= st_hi);
      r_i  = (c == rs);
      v_i  = (c >= 1) && (bi < L) && (c != bub);
      d_i  = v_i ? tile_v[bi] : W'($urandom());
      cycle(r_i, s_i, l_i, v_i, d_i, st_i);
      obs_data[c] = o_data;
      obs_lv[c]   = o_lv;
      obs_busy[c] = o_busy;
      if (o_done && done_cyc < 0) done_cyc = c;
      if (v_i && o_ready) bi++;
    end
  endtask

  task automatic run_table();
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, tbl[k].s, tbl[k].l, tbl[k].v, tbl[k].d, 1'b0);
      chk($sformatf("tbl%0d_data", k), o_data, tbl[k].e_data);
      chk($sformatf("tbl%0d_lv", k), W'(o_lv), W'(tbl[k].e_lv));
      chk($sformatf("tbl%0d_busy", k), W'(o_busy), W'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_done", k), W'(o_done), W'(tbl[k].e_done));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd3, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd3, 1'b1, 32'h04030201, 32'h00000000, 4'b0000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd3, 1'b1, 32'h08070605, 32'h00000001, 4'b0001, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd3, 1'b1, 32'h0c0b0a09, 32'h00000205, 4'b0011, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd3, 1'b0, 32'h0,        32'h00030609, 4'b0111, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'd3, 1'b0, 32'h0,        32'h04070a00, 4'b1110, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'd3, 1'b0, 32'h0,        32'h080b0000, 4'b1100, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'd3, 1'b0, 32'h0,        32'h0c000000, 4'b1000, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'd3, 1'b0, 32'h0,        32'h00000000, 4'b0000, 1'b0, 1'b0};
    tile_v[0] = 32'h04030201;
    tile_v[1] = 32'h08070605;
    tile_v[2] = 32'h0c0b0a09;
    for (int i = 3; i < 8; i++) tile_v[i] = '0;

    // Clock/reset
    @(posedge clk);
    #1;
    model_step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("rst_out_data", o_data, '0);
    chk("rst_busy", W'(o_busy), '0);

    // Nominal tile
    run_table();

    // Stall for two cycles after the second beat
    run_tile(3, 3, 4, -1, -1, -1, 12);
    chk("stall_hold_c4", obs_data[4], 32'h00000205);
    chk("stall_hold_c5", obs_data[5], 32'h00000205);
    chk("stall_lv_c4", W'(obs_lv[4]), W'(4'b0011));
    chk("stall_last_c9", obs_data[9], 32'h0c000000);
    chk("stall_done_cyc", W'(done_cyc), W'(9));

    // Input bubble between beats 1 and 2
    run_tile(3, -1, -2, 2, -1, -1, 12);
    chk("bub_l0_c3", W'(obs_data[3][7:0]), '0);
    chk("bub_lv_c3", W'(obs_lv[3]), W'(4'b0010));
    chk("bub_l0_c4", W'(obs_data[4][7:0]), W'(8'd5));
    chk("bub_done_cyc", W'(done_cyc), W'(8));

    // Signed extremes
    tile_v[0] = 32'h00ff7f80;
    run_tile(1, -1, -2, -1, -1, -1, 8);
    chk("sgn_l0", W'(lane_s(obs_data[2], 0)), W'(-128));
    chk("sgn_l1", W'(lane_s(obs_data[3], 1)), W'(127));
    chk("sgn_l2", W'(lane_s(obs_data[4], 2)), W'(-1));
    chk("sgn_l3_lv", W'(obs_lv[5]), W'(4'b1000));
    chk("sgn_done_cyc", W'(done_cyc), W'(5));
    tile_v[0] = 32'h04030201;

    // Ignored starts: len == 0, then a second start while feeding
    run_tile(0, -1, -2, -1, -1, -1, 6);
    chk("len0_busy", W'(obs_busy[1]), '0);
    chk("len0_done", W'(done_cyc), W'(-1));
    run_tile(3, -1, -2, -1, 2, -1, 10);
    chk("xstart_last_c7", obs_data[7], 32'h0c000000);
    chk("xstart_done_cyc", W'(done_cyc), W'(7));
    chk("xstart_idle_c8", W'(obs_busy[8]), '0);

    // Reset during DRAIN aborts the tile
    run_tile(3, -1, -2, -1, -1, 5, 12);
    chk("rdrain_data_c6", obs_data[6], '0);
    chk("rdrain_lv_c6", W'(obs_lv[6]), '0);
    chk("rdrain_busy_c6", W'(obs_busy[6]), '0);
    chk("rdrain_done", W'(done_cyc), W'(-1));
    run_table();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      logic r_i, s_i, v_i, st_i;
      logic [KW-1:0] l_i;
      r_i  = ($urandom_range(0, 199) == 0);
      s_i  = ($urandom_range(0, 3) == 0);
      l_i  = ($urandom_range(0, 9) == 0) ? KW'(20) : KW'($urandom_range(0, 6));
      v_i  = ($urandom_range(0, 3) != 0);
      st_i = ($urandom_range(0, 3) == 0);
      cycle(r_i, s_i, l_i, v_i, W'($urandom()), st_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
